// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared state encoding, defaults and bit-vector helpers for the MaxNet controller
package maxnet_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_ITER = 16;
  localparam int DEF_CALC_LAT = 1;
  localparam int VEC_W        = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_WAIT,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_t;

  function automatic int popcount(input logic [VEC_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < VEC_W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Returns 0 for an all-zero vector, which is also the reported winner in that case.
  function automatic int lowest_set(input logic [VEC_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = VEC_W - 1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/maxnet_winner_enc.sv
// rtl/maxnet_winner_enc.sv - combinational summary of the positive-activation vector
module maxnet_winner_enc
  import maxnet_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pos_vec,
  output logic             cnt_le1,
  output logic             any_pos,
  output logic [IDX_W-1:0] idx
);

  logic [VEC_W-1:0] vec;

  always_comb begin
    vec     = VEC_W'(pos_vec);
    cnt_le1 = (popcount(vec) <= 1);
    any_pos = |pos_vec;
    idx     = IDX_W'(lowest_set(vec));
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// rtl/maxnet_ctrl.sv - sequencer for the MaxNet load/init/inhibit loop and result capture
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDX_W    = 2,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int CALC_LAT = DEF_CALC_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     pos_vec,
  output logic             mem_rd,
  output logic [IDX_W-1:0] mem_addr,
  output logic             in_ld,
  output logic             act_ld,
  output logic             init_sel,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] winner,
  output logic             no_winner,
  output logic             timeout
);

  localparam int CNT_W  = $clog2(MAX_ITER + 1);
  localparam int WAIT_W = $clog2(CALC_LAT + 1);

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               no_winner_q, no_winner_d;
  logic               timeout_q, timeout_d;

  logic               cnt_le1, any_pos;
  logic [IDX_W-1:0]   enc_idx;

  maxnet_winner_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .pos_vec (pos_vec),
    .cnt_le1 (cnt_le1),
    .any_pos (any_pos),
    .idx     (enc_idx)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    iter_d      = iter_q;
    winner_d    = winner_q;
    no_winner_d = no_winner_q;
    timeout_d   = timeout_q;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    in_ld       = 1'b0;
    act_ld      = 1'b0;
    init_sel    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          iter_d      = '0;
          winner_d    = '0;
          no_winner_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_LOAD: begin
        mem_rd   = 1'b1;
        in_ld    = 1'b1;
        mem_addr = addr_q;
        if (addr_q == IDX_W'(N - 1)) begin
          addr_d  = '0;
          state_d = S_INIT;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_INIT: begin
        act_ld   = 1'b1;
        init_sel = 1'b1;
        wcnt_d   = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_W'(CALC_LAT - 1)) begin
          wcnt_d  = '0;
          state_d = S_CHECK;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      // Convergence outranks the iteration limit when both hold on the same check.
      S_CHECK: begin
        if (cnt_le1) begin
          state_d     = S_DONE;
          winner_d    = enc_idx;
          no_winner_d = !any_pos;
        end else if (iter_q == CNT_W'(MAX_ITER)) begin
          state_d   = S_DONE;
          winner_d  = enc_idx;
          timeout_d = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        act_ld = 1'b1;
        if (iter_q != CNT_W'(MAX_ITER)) iter_d = iter_q + 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign winner    = winner_q;
  assign no_winner = no_winner_q;
  assign timeout   = timeout_q;

  // start_q resets high so a start already asserted at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b1;
      addr_q      <= '0;
      wcnt_q      <= '0;
      iter_q      <= '0;
      winner_q    <= '0;
      no_winner_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      iter_q      <= iter_d;
      winner_q    <= winner_d;
      no_winner_q <= no_winner_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb/tb_maxnet_ctrl.sv - scoreboard bench for the MaxNet controller
module tb_maxnet_ctrl;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_ITER = 16;
  localparam int CALC_LAT = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N-1:0]     pos_vec;
  logic             mem_rd;
  logic [IDX_W-1:0] mem_addr;
  logic             in_ld;
  logic             act_ld;
  logic             init_sel;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] winner;
  logic             no_winner;
  logic             timeout;

  maxnet_ctrl #(.N(N), .IDX_W(IDX_W), .MAX_ITER(MAX_ITER), .CALC_LAT(CALC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pos_vec   (pos_vec),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .in_ld     (in_ld),
    .act_ld    (act_ld),
    .init_sel  (init_sel),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .no_winner (no_winner),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int done_cyc;
    int winner;
    int nw;
    int to;
    int iters;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] seq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int iter_seen = 0;
  int done_cnt = 0;
  int mon_rel = 0;
  bit run_active = 1'b0;
  bit chk_after_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] seq_at(input int k);
    return seq[(k < seq.size()) ? k : seq.size() - 1];
  endfunction

  // Reference behaviour: walk the pos_vec sequence check by check.
  function automatic exp_t model();
    exp_t e;
    logic [N-1:0] p;
    int pc, lo;
    e = '{done_cyc: 0, winner: 0, nw: 0, to: 0, iters: -1};
    for (int k = 0; k <= MAX_ITER && e.iters < 0; k++) begin
      p = seq_at(k);
      pc = 0;
      lo = -1;
      for (int i = 0; i < N; i++) if (p[i]) begin
        pc++;
        if (lo < 0) lo = i;
      end
      if (pc <= 1) begin
        e.winner = (pc == 1) ? lo : 0;
        e.nw     = (pc == 0);
        e.iters  = k;
      end else if (k == MAX_ITER) begin
        e.winner = lo;
        e.to     = 1;
        e.iters  = k;
      end
    end
    e.done_cyc = N + 2 + (e.iters + 1) * (CALC_LAT + 1) + e.iters;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mon_rel = cyc - start_cyc;
      if (chk_after_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk_after_done = 1'b0;
      end
      if (run_active) begin
        if (mon_rel >= 1 && mon_rel <= N + 1) begin
          chk($sformatf("in_ld@%0d", mon_rel), in_ld, int'(mon_rel <= N));
          chk($sformatf("mem_rd@%0d", mon_rel), mem_rd, int'(mon_rel <= N));
          chk($sformatf("mem_addr@%0d", mon_rel), mem_addr, (mon_rel <= N) ? mon_rel - 1 : 0);
          chk($sformatf("act_ld@%0d", mon_rel), act_ld, int'(mon_rel == N + 1));
          chk($sformatf("init_sel@%0d", mon_rel), init_sel, int'(mon_rel == N + 1));
          chk($sformatf("busy@%0d", mon_rel), busy, 1);
        end
        if (act_ld && !init_sel) begin
          iter_seen++;
          pos_vec = seq_at(iter_seen);
        end
        if (done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", mon_rel, e.done_cyc);
            chk("winner", winner, e.winner);
            chk("no_winner", no_winner, e.nw);
            chk("timeout", timeout, e.to);
            chk("iter_pulses", iter_seen, e.iters);
          end
          run_active = 1'b0;
          chk_after_done = 1'b1;
        end
      end else if (done) begin
        done_cnt++;
        chk("stray_done", done, 0);
      end
    end
  end

  task automatic run(input int hold);
    exp_t e;
    @(posedge clk);
    #1;
    e = model();
    sb.push_back(e);
    iter_seen  = 0;
    pos_vec    = seq[0];
    start      = 1'b1;
    start_cyc  = cyc;
    run_active = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("run_finished", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_in_ld"}, in_ld, 0);
    chk({tag, "_act_ld"}, act_ld, 0);
    chk({tag, "_init_sel"}, init_sel, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_no_winner"}, no_winner, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int d0;
    rst     = 1'b1;
    start   = 1'b1;
    pos_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_start_no_run", done_cnt, 0);
    chk("held_start_idle", busy, 0);
    start = 1'b0;

    seq = '{4'b0001};
    run(1);
    wait_done();

    seq = '{4'b1011, 4'b0011, 4'b0010};
    run(1);
    wait_done();
    chk("winner_held", winner, 1);

    seq = '{4'b1111};
    run(1);
    wait_done();

    seq = '{4'b0000};
    run(1);
    wait_done();

    seq = '{4'b0110, 4'b0100};
    d0 = done_cnt;
    run(3);
    repeat (500) @(posedge clk);
    #1;
    chk("single_run_per_edge", done_cnt - d0, 1);
    chk("long_start_sb", sb.size(), 0);

    seq = '{4'b1111};
    run(1);
    for (int i = 0; i < 100 && iter_seen < 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reached_iter2", iter_seen, 2);
    @(posedge clk);
    #1;
    chk("busy_before_rst", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    sb.delete();
    run_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    seq = '{4'b0100};
    run(1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxnet_ctrl.md
# maxnet_ctrl

Control FSM that sequences the MaxNet winner-take-all datapath. On a `start` rising edge it loads the N input activations from the input memory, initialises the activation registers and repeats the inhibition update until at most one neuron stays positive, or until an iteration limit is reached. It reports the winner index together with status flags and a one-cycle `done` pulse. It sits between the top-level handshake (`start`/`done`) and the activation registers, input memory and compare logic of the datapath.

## Interface
- `N`, 4: number of neurons (≥2).
- `IDX_W`, 2: index width, equals clog2(N).
- `MAX_ITER`, 16: maximum number of update iterations before timeout.
- `CALC_LAT`, 1: settle cycles for the datapath update (≥1).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request; only the rising edge is used.
- `pos_vec` in N: from the datapath; bit i is set when activation i > 0.
- `mem_rd` out 1: input memory read strobe.
- `mem_addr` out IDX_W: input memory address, which is also the index of the input register being loaded.
- `in_ld` out 1: load input register `mem_addr` with the memory data.
- `act_ld` out 1: load the activation registers.
- `init_sel` out 1: activation mux select; 1 = inputs, 0 = update result.
- `busy` out 1: high from LOAD through DONE.
- `done` out 1: one-cycle completion pulse.
- `winner` out IDX_W: winning neuron index; held until the next run.
- `no_winner` out 1: all activations ≤ 0 at termination; held.
- `timeout` out 1: terminated at `MAX_ITER`; held.

## Operation
- States: IDLE, LOAD, INIT, WAIT, CHECK, ITER, DONE.
- `start_q` register; edge = `start & ~start_q`. `start_q` resets to 1, so a `start` held high through reset release does not launch a run.
- IDLE: on edge, go to LOAD and clear `iter_cnt`, `winner`, `no_winner` and `timeout`. Edges in any other state are ignored.
- LOAD: N cycles. `mem_rd=in_ld=1`, `mem_addr` counts 0..N-1. Go to INIT after address N-1.
- INIT: 1 cycle. `act_ld=1`, `init_sel=1`. Go to WAIT.
- WAIT: `CALC_LAT` cycles with no loads. Go to CHECK.
- CHECK: 1 cycle, evaluates `pos_vec`; the first matching rule applies.
  - popcount ≤ 1 → DONE.
  - `iter_cnt == MAX_ITER` → DONE with `timeout=1`.
  - otherwise → ITER.
- ITER: 1 cycle. `act_ld=1`, `init_sel=0`, `iter_cnt++`. Go to WAIT.
- DONE: 1 cycle. `done=1`. Go to IDLE.
- Result capture happens on the CHECK→DONE transition:
  - popcount = 1: `winner` = index of the set bit.
  - popcount = 0: `winner=0`, `no_winner=1`.
  - timeout: `winner` = lowest set index.
- `iter_cnt` width is clog2(MAX_ITER+1) and never wraps.
- `init_sel` is 0 except in INIT. `mem_addr` is 0 outside LOAD.

## Timing
- Reset (asynchronous, at any time, including mid-run): state IDLE. All outputs and counters go to 0; `start_q` goes to 1.
- Start edge sampled in cycle 0 → LOAD in cycles 1..N → INIT N+1 → WAIT → CHECK → DONE.
- Latency with k iterations: `done` is high in cycle N + 2 + (k+1)(CALC_LAT+1) + k.
- With defaults, k=0 gives `done` in cycle 8; each extra iteration adds CALC_LAT+2 = 3 cycles.
- `busy` falls in the cycle after `done`. A new run needs a fresh rising edge on `start`, seen in IDLE.
- `pos_vec` is sampled only in CHECK, so its value in other states has no effect.

## Structure
- `maxnet_pkg`:
  - state enum;
  - default constants for `N`, `MAX_ITER` and `CALC_LAT`;
  - popcount and lowest-set-index functions.
- Sub-module `maxnet_winner_enc` (combinational) takes `pos_vec` and produces `cnt_le1`, `any_pos` and `idx`; it is used in CHECK.

## Test plan
- Reset, then a start edge with `pos_vec=0001` → `mem_addr` goes 0,1,2,3 in cycles 1-4, `act_ld`/`init_sel` high in cycle 5, `done` in cycle 8, `winner=0`, flags 0.
- `pos_vec` sequence 1011, 0011, 0010 at the successive CHECKs → two ITER pulses with `init_sel=0`, `done` in cycle 14, `winner=1`.
- `pos_vec=1111` held constantly, `MAX_ITER=16` → exactly 16 ITER pulses, `done` in cycle 56, `timeout=1`, `winner=0`.
- `pos_vec=0000` at the first CHECK → `done` in cycle 8, `no_winner=1`, `winner=0`.
- `start` held high for 3 cycles, then low for 500 cycles → exactly one run and one `done` pulse.
- `rst` asserted during WAIT of iteration 2 → all outputs are 0 immediately, without waiting for a clock edge. A later start edge gives a normal run (`done` in cycle 8 for `pos_vec=0100`, `winner=2`).
